// File: rtl/dart_engine.sv
// dart_engine: multi-slot projectile engine.
// Holds up to NUM_DARTS darts in flight. Each dart moves toward its
// destination by at most STEP pixels per axis on every frame_tick. A dart
// that reaches its destination is reported as a hit on hit_* and its slot
// becomes free again. Hits are reported one per cycle, lowest slot first.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   frame_tick            one-cycle motion strobe
//   flush                 clears all slots and any pending hit
//   fire_req, fire_src_*, fire_dst_*   launch request with source and target
//   fire_ready            at least one slot is free (registered state only)
//   darts_out             per slot {active, x, y}, slot 0 in the low bits
//   hit_valid, hit_x, hit_y, hit_slot  registered one-cycle hit report
module dart_engine #(
  parameter int COORD_W   = 10,
  parameter int NUM_DARTS = 4,
  parameter int STEP      = 4,
  localparam int SLOT_W   = (NUM_DARTS > 1) ? $clog2(NUM_DARTS) : 1,
  localparam int SW       = 2 * COORD_W + 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_tick,
  input  logic                      flush,
  input  logic                      fire_req,
  input  logic [COORD_W-1:0]        fire_src_x,
  input  logic [COORD_W-1:0]        fire_src_y,
  input  logic [COORD_W-1:0]        fire_dst_x,
  input  logic [COORD_W-1:0]        fire_dst_y,
  output logic                      fire_ready,
  output logic [NUM_DARTS*SW-1:0]   darts_out,
  output logic                      hit_valid,
  output logic [COORD_W-1:0]        hit_x,
  output logic [COORD_W-1:0]        hit_y,
  output logic [SLOT_W-1:0]         hit_slot
);

  localparam logic [1:0] S_FREE = 2'd0;
  localparam logic [1:0] S_FLY  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic signed [COORD_W:0] STEP_S = (COORD_W+1)'(STEP);
  localparam logic [COORD_W-1:0]      STEP_C = COORD_W'(STEP);

  logic [1:0]         st_q  [NUM_DARTS];
  logic [1:0]         st_d  [NUM_DARTS];
  logic [COORD_W-1:0] x_q   [NUM_DARTS];
  logic [COORD_W-1:0] x_d   [NUM_DARTS];
  logic [COORD_W-1:0] y_q   [NUM_DARTS];
  logic [COORD_W-1:0] y_d   [NUM_DARTS];
  logic [COORD_W-1:0] dx_q  [NUM_DARTS];
  logic [COORD_W-1:0] dx_d  [NUM_DARTS];
  logic [COORD_W-1:0] dy_q  [NUM_DARTS];
  logic [COORD_W-1:0] dy_d  [NUM_DARTS];

  logic               free_any, done_any;
  logic [SLOT_W-1:0]  free_idx, done_idx;

  logic               hit_valid_q;
  logic [COORD_W-1:0] hit_x_q, hit_y_q;
  logic [SLOT_W-1:0]  hit_slot_q;

  // One axis of Chebyshev motion. The difference is taken one bit wider
  // than the coordinate so a full-range move cannot wrap.
  function automatic logic [COORD_W-1:0] step_axis(
    input logic [COORD_W-1:0] cur,
    input logic [COORD_W-1:0] dst
  );
    logic signed [COORD_W:0] diff;
    diff = $signed({1'b0, dst}) - $signed({1'b0, cur});
    if (diff <= STEP_S && diff >= -STEP_S) return dst;
    else if (!diff[COORD_W])               return cur + STEP_C;
    else                                   return cur - STEP_C;
  endfunction

  // Priority encoders: scanning downward leaves the lowest index in place.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    done_any = 1'b0;
    done_idx = '0;
    for (int i = NUM_DARTS - 1; i >= 0; i--) begin
      if (st_q[i] == S_FREE) begin
        free_any = 1'b1;
        free_idx = SLOT_W'(i);
      end
      if (st_q[i] == S_DONE) begin
        done_any = 1'b1;
        done_idx = SLOT_W'(i);
      end
    end
  end

  // A slot is in exactly one state, so launch (FREE), motion (FLY) and
  // arbitration (DONE) never compete for the same slot in one cycle.
  always_comb begin
    for (int i = 0; i < NUM_DARTS; i++) begin
      st_d[i] = st_q[i];
      x_d[i]  = x_q[i];
      y_d[i]  = y_q[i];
      dx_d[i] = dx_q[i];
      dy_d[i] = dy_q[i];
      case (st_q[i])
        S_FREE: begin
          if (fire_req && free_any && free_idx == SLOT_W'(i)) begin
            st_d[i] = S_FLY;
            x_d[i]  = fire_src_x;
            y_d[i]  = fire_src_y;
            dx_d[i] = fire_dst_x;
            dy_d[i] = fire_dst_y;
          end
        end
        S_FLY: begin
          if (frame_tick) begin
            x_d[i] = step_axis(x_q[i], dx_q[i]);
            y_d[i] = step_axis(y_q[i], dy_q[i]);
            if (x_d[i] == dx_q[i] && y_d[i] == dy_q[i]) st_d[i] = S_DONE;
          end
        end
        S_DONE: begin
          if (done_any && done_idx == SLOT_W'(i)) st_d[i] = S_FREE;
        end
        default: st_d[i] = S_FREE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_DARTS; i++) begin
        st_q[i] <= S_FREE;
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        dx_q[i] <= '0;
        dy_q[i] <= '0;
      end
      hit_valid_q <= 1'b0;
      hit_x_q     <= '0;
      hit_y_q     <= '0;
      hit_slot_q  <= '0;
    end else if (flush) begin
      // Coordinates keep their last values; only the slot states clear.
      for (int i = 0; i < NUM_DARTS; i++) st_q[i] <= S_FREE;
      hit_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DARTS; i++) begin
        st_q[i] <= st_d[i];
        x_q[i]  <= x_d[i];
        y_q[i]  <= y_d[i];
        dx_q[i] <= dx_d[i];
        dy_q[i] <= dy_d[i];
      end
      hit_valid_q <= done_any;
      if (done_any) begin
        hit_x_q    <= dx_q[done_idx];
        hit_y_q    <= dy_q[done_idx];
        hit_slot_q <= done_idx;
      end
    end
  end

  for (genvar g = 0; g < NUM_DARTS; g++) begin : g_out
    assign darts_out[g*SW +: SW] = {st_q[g] == S_FLY, x_q[g], y_q[g]};
  end

  assign fire_ready = free_any;
  assign hit_valid  = hit_valid_q;
  assign hit_x      = hit_x_q;
  assign hit_y      = hit_y_q;
  assign hit_slot   = hit_slot_q;

endmodule

// File: tb/tb_dart_engine.sv
module tb_dart_engine;

  localparam int W  = 10;
  localparam int N  = 4;
  localparam int SW = 2 * W + 1;

  logic           Clk = 1'b0;
  logic           Reset, frame_tick, flush, fire_req;
  logic [W-1:0]   fire_src_x, fire_src_y, fire_dst_x, fire_dst_y;
  logic           fire_ready;
  logic [N*SW-1:0] darts_out;
  logic           hit_valid;
  logic [W-1:0]   hit_x, hit_y;
  logic [1:0]     hit_slot;

  int n_cmp = 0;
  int n_err = 0;

  dart_engine #(.COORD_W(W), .NUM_DARTS(N), .STEP(4)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .flush(flush),
    .fire_req(fire_req), .fire_src_x(fire_src_x), .fire_src_y(fire_src_y),
    .fire_dst_x(fire_dst_x), .fire_dst_y(fire_dst_y), .fire_ready(fire_ready),
    .darts_out(darts_out), .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y),
    .hit_slot(hit_slot)
  );

  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] px(int i);
    return darts_out[i*SW+W +: W];
  endfunction
  function automatic logic [W-1:0] py(int i);
    return darts_out[i*SW +: W];
  endfunction
  function automatic logic act(int i);
    return darts_out[i*SW+2*W];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic fire(input int sx, input int sy, input int dx, input int dy);
    fire_req   = 1'b1;
    fire_src_x = W'(sx);
    fire_src_y = W'(sy);
    fire_dst_x = W'(dx);
    fire_dst_y = W'(dy);
    cyc();
    fire_req = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic chk_pos(input string tag, input int i, input logic a, input int x, input int y);
    chk({tag, ".act"}, 128'(act(i)), 128'(a));
    chk({tag, ".x"}, 128'(px(i)), 128'(x));
    chk({tag, ".y"}, 128'(py(i)), 128'(y));
  endtask

  task automatic chk_hit(input string tag, input int x, input int y, input int s);
    chk({tag, ".valid"}, 128'(hit_valid), 128'(1));
    chk({tag, ".x"}, 128'(hit_x), 128'(x));
    chk({tag, ".y"}, 128'(hit_y), 128'(y));
    chk({tag, ".slot"}, 128'(hit_slot), 128'(s));
  endtask

  logic [N*SW-1:0] saved;

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; flush = 1'b0; fire_req = 1'b0;
    fire_src_x = '0; fire_src_y = '0; fire_dst_x = '0; fire_dst_y = '0;
    cyc(); cyc();
    Reset = 1'b0;

    // Reset state
    chk("rst.darts", 128'(darts_out), 128'(0));
    chk("rst.hit_valid", 128'(hit_valid), 128'(0));
    chk("rst.hit_x", 128'(hit_x), 128'(0));
    chk("rst.hit_y", 128'(hit_y), 128'(0));
    chk("rst.hit_slot", 128'(hit_slot), 128'(0));
    chk("rst.ready", 128'(fire_ready), 128'(1));

    // Single dart (100,50) -> (110,44)
    fire(100, 50, 110, 44);
    chk_pos("t1.launch", 0, 1'b1, 100, 50);
    tick(); chk_pos("t1.tick1", 0, 1'b1, 104, 46);
    tick(); chk_pos("t1.tick2", 0, 1'b1, 108, 44);
    tick(); chk_pos("t1.tick3", 0, 1'b0, 110, 44);
    chk("t1.no_hit_yet", 128'(hit_valid), 128'(0));
    cyc();  chk_hit("t1.hit", 110, 44, 0);
    chk("t1.ready", 128'(fire_ready), 128'(1));
    cyc();  chk("t1.hit_drop", 128'(hit_valid), 128'(0));

    // Fill all four slots, fifth request dropped
    fire(10, 20, 500, 500);
    fire(20, 20, 500, 500);
    fire(30, 20, 500, 500);
    chk("fill.ready3", 128'(fire_ready), 128'(1));
    fire(40, 20, 500, 500);
    chk("fill.ready4", 128'(fire_ready), 128'(0));
    chk_pos("fill.s0", 0, 1'b1, 10, 20);
    chk_pos("fill.s3", 3, 1'b1, 40, 20);
    saved = darts_out;
    fire(7, 7, 9, 9);
    chk("fill.drop", 128'(darts_out), 128'(saved));
    chk("fill.ready5", 128'(fire_ready), 128'(0));
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("fill.flush_ready", 128'(fire_ready), 128'(1));
    chk("fill.flush_act", 128'({act(0), act(1), act(2), act(3)}), 128'(0));

    // Simultaneous arrival of slots 0 and 2
    fire(0, 0, 4, 0);
    fire(0, 0, 100, 100);
    fire(10, 10, 12, 13);
    tick();
    chk_pos("sim.s1", 1, 1'b1, 4, 4);
    chk("sim.act0", 128'(act(0)), 128'(0));
    chk("sim.act2", 128'(act(2)), 128'(0));
    chk("sim.nohit", 128'(hit_valid), 128'(0));
    cyc(); chk_hit("sim.hitA", 4, 0, 0);
    cyc(); chk_hit("sim.hitB", 12, 13, 2);
    cyc(); chk("sim.end", 128'(hit_valid), 128'(0));
    flush = 1'b1; cyc(); flush = 1'b0;

    // Zero distance
    fire(5, 5, 5, 5);
    chk_pos("zero.launch", 0, 1'b1, 5, 5);
    tick(); chk_pos("zero.tick", 0, 1'b0, 5, 5);
    cyc();  chk_hit("zero.hit", 5, 5, 0);
    cyc();

    // Extreme diagonal (1023,0) -> (0,1023)
    fire(1023, 0, 0, 1023);
    for (int k = 0; k < 255; k++) tick();
    chk_pos("ext.t255", 0, 1'b1, 3, 1020);
    tick(); chk_pos("ext.t256", 0, 1'b0, 0, 1023);
    cyc();  chk_hit("ext.hit", 0, 1023, 0);
    cyc();

    // Launch in the same cycle as a tick
    frame_tick = 1'b1;
    fire(200, 200, 300, 300);
    frame_tick = 1'b0;
    chk_pos("same.launch", 0, 1'b1, 200, 200);
    tick(); chk_pos("same.tick", 0, 1'b1, 204, 204);

    // Flush with three darts flying and one arrival pending
    fire(50, 50, 50, 52);
    fire(60, 60, 600, 600);
    tick();
    chk("fl.s1done", 128'(act(1)), 128'(0));
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("fl.act", 128'({act(0), act(1), act(2), act(3)}), 128'(0));
    chk("fl.hit", 128'(hit_valid), 128'(0));
    chk("fl.ready", 128'(fire_ready), 128'(1));
    cyc(); chk("fl.hit2", 128'(hit_valid), 128'(0));

    // Flush drops a hit already in the output register
    fire(1, 1, 1, 1);
    tick(); cyc();
    chk_hit("flh.hit", 1, 1, 0);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("flh.drop", 128'(hit_valid), 128'(0));

    // Reset mid-flight
    fire(100, 100, 400, 400);
    fire(110, 100, 400, 400);
    fire(120, 100, 400, 400);
    tick();
    chk("rs.flying", 128'({act(0), act(1), act(2)}), 128'(3'b111));
    Reset = 1'b1; cyc(); Reset = 1'b0;
    chk("rs.darts", 128'(darts_out), 128'(0));
    chk("rs.hit_valid", 128'(hit_valid), 128'(0));
    chk("rs.hit_x", 128'(hit_x), 128'(0));
    chk("rs.hit_y", 128'(hit_y), 128'(0));
    chk("rs.hit_slot", 128'(hit_slot), 128'(0));
    chk("rs.ready", 128'(fire_ready), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dart_engine.md
# dart_engine

Multi-slot projectile engine: the parametrised successor to the single-dart shooter. It accepts fire requests (source and destination coordinates) from the monkey/tower logic and holds up to NUM_DARTS darts in flight. Each dart advances toward its destination by at most STEP pixels per axis per frame tick. On arrival, one hit event per cycle is reported to the bloon logic. It sits between tower targeting and bloon hit processing; the packed dart vector feeds the sprite renderer.

## Interface
- COORD_W, 10: coordinate width per axis (X and Y unsigned).
- NUM_DARTS, 4: number of dart slots (1..16).
- STEP, 4: max per-axis move per frame_tick (1 ≤ STEP < 2^COORD_W).
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle motion strobe (once per video frame).
- flush  in  1  synchronous clear of all slots and pending hits (level restart).
- fire_req  in  1  launch request.
- fire_src_x / fire_src_y  in  COORD_W each  launch position.
- fire_dst_x / fire_dst_y  in  COORD_W each  target position.
- fire_ready  out  1  at least one slot FREE (from registered state only).
- darts_out  out  NUM_DARTS*(2*COORD_W+1)  per slot i, bits [i*(2W+1) +: 2W+1] = {active, x, y}, same layout as the existing 21-bit dartfile word.
- hit_valid  out  1  one-cycle hit pulse.
- hit_x / hit_y  out  COORD_W each  hit position (= destination).
- hit_slot  out  $clog2(NUM_DARTS) (min 1)  slot that hit.

## Operation
- Per-slot state: FREE, FLY, DONE. Per slot, registered x, y, dst_x, dst_y.
- Launch: fire_req && fire_ready → lowest-index FREE slot → FLY, x/y ← src, dst ← dst. fire_req while !fire_ready is dropped; no queueing.
- Motion: on frame_tick, every FLY slot moves each axis independently. dx = dst_x − x, signed, COORD_W+1 bits. If |dx| ≤ STEP, x ← dst_x; else x ← x ± STEP. Y is handled identically. Diagonal paths are Chebyshev, not Bresenham.
- Arrival: after the update, if (x,y) == (dst_x,dst_y), the slot goes FLY → DONE at the same edge. A dart launched with src == dst goes DONE on its first frame_tick with no movement.
- A slot launched in the same cycle as a frame_tick does not move on that tick.
- Hit arbiter: each cycle, pick the lowest-index DONE slot. Register hit_valid=1, hit_x/hit_y=dst, hit_slot=index. That slot → FREE. Other DONE slots wait, one reported per cycle.
- DONE slots ignore frame_tick.
- darts_out active bit = (state == FLY). DONE and FREE slots show active=0. Coordinates of inactive slots hold their last values.
- flush: all slots → FREE, no hit emitted, hit_valid=0 next cycle. Precedence is flush/Reset > fire/motion/arbiter.
- Reset: all slots FREE, all slot registers 0. Outputs are darts_out=0, hit_valid=0, hit_x=hit_y=0, hit_slot=0, fire_ready=1 (first cycle after reset).

## Timing
- Launch accepted at edge E. The slot is visible in darts_out and fire_ready updates in the cycle after E.
- A slot freed by the arbiter at edge E is allocatable by a fire_req presented in the cycle after E, never in the same cycle.
- frame_tick in cycle T → new positions visible T+1. If that tick causes arrival, the slot is DONE in T+1; with no older DONE slots, hit_valid is high in T+2 and the slot is FREE (fire_ready=1) in T+2.
- k slots arriving on the same tick → k consecutive hit_valid cycles, in ascending slot order.
- Max distance 2^COORD_W−1 per axis; subtraction must not wrap (W+1-bit signed).
- Reset or flush mid-flight: state cleared at that edge; a hit already in the output register drops to 0 next cycle.

## Test plan
- Single dart, STEP=4: fire src (100,50) dst (110,44), then 3 frame_ticks → positions (104,46), (108,44), (110,44). hit_valid exactly 2 cycles after the 3rd tick, hit=(110,44), slot 0, fire_ready returns 1.
- Fill: 4 fires back-to-back → slots 0..3. A 5th fire_req with fire_ready=0 is dropped, and no slot changes.
- Simultaneous arrival: slots 0 and 2 both reach their targets on the same tick → hit_valid in two consecutive cycles, slot 0 then slot 2.
- Zero-distance and extremes: src=dst=(5,5) → hit at the 1st tick. Src (1023,0) dst (0,1023) → reaches the destination after 256 ticks, with no wrap.
- Same-cycle launch and tick: fire asserted with frame_tick → the slot stays at src. The next tick moves it by STEP.
- Flush and Reset mid-flight: 3 darts flying, flush → all active=0, no hit_valid, fire_ready=1. The same sequence with Reset gives all outputs at their reset values.
